// File: rtl/synth_pkg.sv
// ----------------------------------------------------------------------------
// synth_pkg
// Shared definitions for the synthesizer voice path.
//   mode_t    : waveform select, shared with the mode-select FSM
//   SAMPLE_W  : sample and phase width (fixed at 8)
//   SMP_MIN / SMP_MAX : full-scale low/high sample values
// ----------------------------------------------------------------------------
package synth_pkg;

    typedef enum logic [1:0] {
        MODE_OFF      = 2'd0,
        MODE_SQUARE   = 2'd1,
        MODE_TRIANGLE = 2'd2,
        MODE_SAW      = 2'd3
    } mode_t;

    localparam int SAMPLE_W = 8;

    localparam logic [SAMPLE_W-1:0] SMP_MIN = 8'h00;
    localparam logic [SAMPLE_W-1:0] SMP_MAX = 8'hFF;

endpackage

// File: rtl/wave_shaper.sv
// ----------------------------------------------------------------------------
// wave_shaper
// Purely combinational phase-to-sample mapping.
//   mode  in  2  waveform select (mode_t encoding)
//   phase in  8  phase accumulator value
//   wave  out 8  shaped sample for (mode, phase)
// ----------------------------------------------------------------------------
module wave_shaper (
    input  logic [1:0] mode,
    input  logic [7:0] phase,
    output logic [7:0] wave
);
    import synth_pkg::*;

    logic [SAMPLE_W-1:0] tri_ramp;

    // Triangle: double the phase, fold the second half back down.
    assign tri_ramp = {phase[SAMPLE_W-2:0], 1'b0};

    always_comb begin
        // NOTE: default first so every path assigns wave and no latch is inferred.
        wave = SMP_MIN;
        case (mode_t'(mode))
            MODE_OFF:      wave = SMP_MIN;
            MODE_SQUARE:   wave = phase[SAMPLE_W-1] ? SMP_MAX : SMP_MIN;
            MODE_TRIANGLE: wave = phase[SAMPLE_W-1] ? ~tri_ramp : tri_ramp;
            MODE_SAW:      wave = phase;
            default:       wave = SMP_MIN;
        endcase
    end

endmodule

// File: rtl/wave_gen.sv
// ----------------------------------------------------------------------------
// wave_gen
// Oscillator stage: divisor counter plus 8-bit phase accumulator, shaped into
// an 8-bit sample stream. Output period is 256 * divisor clock cycles.
//   clk          in  1      system clock
//   n_rst        in  1      asynchronous reset, active-high
//   mode         in  2      0 off, 1 square, 2 triangle, 3 sawtooth
//   en           in  1      note active; 0 = silence
//   divisor      in  DIV_W  clock cycles per phase step; 0 = stalled
//   sample       out 8      current sample, registered
//   sample_strb  out 1      one-cycle pulse on every sample update
// ----------------------------------------------------------------------------
module wave_gen #(
    parameter int DIV_W    = 16,
    parameter int SAMPLE_W = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [1:0]       mode,
    input  logic             en,
    input  logic [DIV_W-1:0] divisor,
    output logic [7:0]       sample,
    output logic             sample_strb
);
    import synth_pkg::*;

    logic [DIV_W-1:0]    cnt;
    logic [SAMPLE_W-1:0] phase;
    logic [1:0]          mode_q;

    logic [SAMPLE_W-1:0] phase_inc;
    logic [SAMPLE_W-1:0] wave_start;
    logic [SAMPLE_W-1:0] wave_step;

    // Wraps 0xFF -> 0x00 naturally at 8 bits.
    assign phase_inc = phase + SAMPLE_W'(1);

    // Sample at phase 0 for a mode-change restart.
    wave_shaper u_shaper_start (
        .mode  (mode),
        .phase (SMP_MIN),
        .wave  (wave_start)
    );

    // Sample for the upcoming phase step.
    wave_shaper u_shaper_step (
        .mode  (mode),
        .phase (phase_inc),
        .wave  (wave_step)
    );

    // NOTE: n_rst is active-high here; every state register is cleared in the
    // reset branch since the output stage may sample immediately after release.
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            cnt         <= '0;
            phase       <= '0;
            mode_q      <= MODE_OFF;
            sample      <= SMP_MIN;
            sample_strb <= 1'b0;
        end else if (!en) begin
            // mode_q keeps tracking so raising en does not look like a mode change.
            // NOTE: non-blocking assignments keep all registers updating from
            // pre-edge values, independent of statement order.
            mode_q      <= mode;
            cnt         <= '0;
            phase       <= '0;
            sample      <= SMP_MIN;
            sample_strb <= 1'b0;
        end else if (mode != mode_q) begin
            mode_q      <= mode;
            cnt         <= '0;
            phase       <= '0;
            sample      <= wave_start;
            sample_strb <= 1'b1;
        end else if (divisor == '0) begin
            sample_strb <= 1'b0;
        end else if (cnt >= divisor - DIV_W'(1)) begin
            // >= so a divisor lowered below the running count steps right away.
            cnt         <= '0;
            phase       <= phase_inc;
            sample      <= wave_step;
            sample_strb <= 1'b1;
        end else begin
            cnt         <= cnt + DIV_W'(1);
            sample_strb <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wave_gen.sv
// ----------------------------------------------------------------------------
// tb_wave_gen
// Self-checking bench for wave_gen: directed table vectors, hand-written
// corner-case sequences and a randomized run against a reference model.
// ----------------------------------------------------------------------------
module tb_wave_gen;

    logic        clk;
    logic        n_rst;
    logic [1:0]  mode;
    logic        en;
    logic [15:0] divisor;
    logic [7:0]  sample;
    logic        sample_strb;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int   m_cnt;
    int   m_phase;
    int   m_mq;
    int   m_smp;
    logic m_strb;

    typedef struct {
        string      name;
        logic [1:0] mode;
        int         div;
        int         n;
        logic [7:0] exp_s;
        logic       exp_strb;
    } vec_t;

    vec_t vecs[12];

    wave_gen #(.DIV_W(16), .SAMPLE_W(8)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .mode        (mode),
        .en          (en),
        .divisor     (divisor),
        .sample      (sample),
        .sample_strb (sample_strb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Waveform as arithmetic on the phase number.
    function automatic int wave(input int m, input int p);
        case (m)
            1:       return (p >= 128) ? 255 : 0;
            2:       return (p < 128) ? 2 * p : 511 - 2 * p;
            3:       return p;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_phase = 0; m_mq = 0; m_smp = 0; m_strb = 1'b0;
    endtask

    task automatic model_tick();
        if (n_rst) begin
            model_reset();
        end else if (!en) begin
            m_mq = int'(mode); m_cnt = 0; m_phase = 0; m_smp = 0; m_strb = 1'b0;
        end else if (int'(mode) != m_mq) begin
            m_mq = int'(mode); m_cnt = 0; m_phase = 0;
            m_smp = wave(int'(mode), 0); m_strb = 1'b1;
        end else if (divisor == 16'd0) begin
            m_strb = 1'b0;
        end else if (m_cnt >= int'(divisor) - 1) begin
            m_cnt = 0; m_phase = (m_phase + 1) % 256;
            m_smp = wave(int'(mode), m_phase); m_strb = 1'b1;
        end else begin
            m_cnt++; m_strb = 1'b0;
        end
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic step();
        @(posedge clk);
        model_tick();
        @(negedge clk);
        check("model_sample", 32'(sample), 32'(m_smp));
        check("model_strb", 32'(sample_strb), 32'(m_strb));
    endtask

    // Park with en=0 so mode_q takes the new mode, then raise en.
    task automatic start_note(input logic [1:0] m, input int d);
        en = 1'b0; mode = m; divisor = 16'(d);
        step();
        en = 1'b1;
    endtask

    initial begin
        n_rst = 1'b1; en = 1'b0; mode = 2'd0; divisor = 16'd0;
        model_reset();

        vecs[0]  = '{"tri_p64",   2'd2, 1, 64,  8'h80, 1'b1};
        vecs[1]  = '{"tri_p127",  2'd2, 1, 127, 8'hFE, 1'b1};
        vecs[2]  = '{"tri_p128",  2'd2, 1, 128, 8'hFF, 1'b1};
        vecs[3]  = '{"tri_p192",  2'd2, 1, 192, 8'h7F, 1'b1};
        vecs[4]  = '{"tri_p255",  2'd2, 1, 255, 8'h01, 1'b1};
        vecs[5]  = '{"saw_d2_s1", 2'd3, 2, 2,   8'h01, 1'b1};
        vecs[6]  = '{"saw_d2_mid",2'd3, 2, 3,   8'h01, 1'b0};
        vecs[7]  = '{"saw_wrap",  2'd3, 2, 512, 8'h00, 1'b1};
        vecs[8]  = '{"sq_p127",   2'd1, 3, 381, 8'h00, 1'b1};
        vecs[9]  = '{"sq_p128",   2'd1, 3, 384, 8'hFF, 1'b1};
        vecs[10] = '{"sq_p256",   2'd1, 3, 768, 8'h00, 1'b1};
        vecs[11] = '{"off_strb",  2'd0, 1, 5,   8'h00, 1'b1};

        repeat (2) @(negedge clk);
        check("reset_sample", 32'(sample), 32'h00);
        check("reset_strb", 32'(sample_strb), 32'h0);
        n_rst = 1'b0;

        // Table-driven vectors
        foreach (vecs[i]) begin
            start_note(vecs[i].mode, vecs[i].div);
            repeat (vecs[i].n) step();
            check({vecs[i].name, "_sample"}, 32'(sample), 32'(vecs[i].exp_s));
            check({vecs[i].name, "_strb"}, 32'(sample_strb), 32'(vecs[i].exp_strb));
        end

        // Lowering divisor below the running count steps on the next edge
        start_note(2'd3, 100);
        repeat (50) step();
        check("div_hi_sample", 32'(sample), 32'h00);
        divisor = 16'd5;
        step();
        check("div_lo_sample", 32'(sample), 32'h01);
        check("div_lo_strb", 32'(sample_strb), 32'h1);

        // Async reset mid-count clears outputs without a clock edge
        divisor = 16'd100;
        repeat (20) step();
        check("pre_rst_sample", 32'(sample), 32'h01);
        #2 n_rst = 1'b1;
        #1;
        check("async_rst_sample", 32'(sample), 32'h00);
        check("async_rst_strb", 32'(sample_strb), 32'h0);
        model_reset();
        step();
        n_rst = 1'b0;

        // Mode change saw -> square at phase 0x90, then stall, then restart
        start_note(2'd3, 1);
        repeat (144) step();
        check("saw_p90", 32'(sample), 32'h90);
        mode = 2'd1;
        step();
        check("mchg_sample", 32'(sample), 32'h00);
        check("mchg_strb", 32'(sample_strb), 32'h1);
        divisor = 16'd0;
        repeat (10) step();
        check("stall_sample", 32'(sample), 32'h00);
        check("stall_strb", 32'(sample_strb), 32'h0);
        divisor = 16'd1;
        repeat (128) step();
        check("restart_sq_p128", 32'(sample), 32'hFF);

        // en drop together with a mode change: en wins, mode_q still follows
        start_note(2'd3, 1);
        repeat (10) step();
        check("saw_p10", 32'(sample), 32'h0A);
        en = 1'b0; mode = 2'd2;
        step();
        check("endrop_sample", 32'(sample), 32'h00);
        check("endrop_strb", 32'(sample_strb), 32'h0);
        en = 1'b1; divisor = 16'd4;
        repeat (3) step();
        check("reen_wait_strb", 32'(sample_strb), 32'h0);
        step();
        check("reen_strb", 32'(sample_strb), 32'h1);
        check("reen_sample", 32'(sample), 32'h02);

        // Randomized run against the model
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 99) < 2) en = ~en;
            if ($urandom_range(0, 99) < 2) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) < 3) divisor = 16'($urandom_range(0, 6));
            if ($urandom_range(0, 999) == 0) begin
                #2 n_rst = 1'b1;
                #1 model_reset();
                step();
                n_rst = 1'b0;
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wave_gen.md
# wave_gen

Oscillator stage directly downstream of the mode-select FSM. It consumes the 2-bit waveform mode (off/square/triangle/sawtooth) plus a per-note clock divisor, and produces an 8-bit sample stream with a one-cycle update strobe for the output (PWM/DAC) stage. It is built around a divisor counter and an 8-bit phase accumulator. Output waveform period is 256 × divisor clock cycles.

## Interface
Parameters:
- DIV_W, 16, width of divisor and internal tick counter
- SAMPLE_W, 8, sample and phase width; fixed at 8, other values unsupported

Ports:
- clk  in  1  system clock
- n_rst  in  1  reset n_rst, asynchronous, active-high
- mode  in  2  waveform select: 0 off, 1 square, 2 triangle, 3 sawtooth
- en  in  1  note active; 0 = silence
- divisor  in  DIV_W  clock cycles per phase step; 0 = stalled
- sample  out  8  current sample, registered
- sample_strb  out  1  one-cycle pulse on every sample update

## Operation
- State: cnt[DIV_W-1:0], phase[7:0], mode_q[1:0] (last-seen mode), sample, sample_strb.
- Shaping function wave(m, p):
  - off: 0x00
  - square: p[7] ? 0xFF : 0x00
  - sawtooth: p
  - triangle: t = {p[6:0],1'b0}; p[7] ? ~t : t
- Priority per cycle, highest first:
  1. en=0: cnt←0, phase←0, sample←0x00, strb←0.
  2. mode≠mode_q: mode_q←mode, cnt←0, phase←0, sample←wave(mode,0), strb←1.
  3. divisor=0: hold cnt, phase, sample; strb←0.
  4. cnt ≥ divisor−1: cnt←0, phase←phase+1 (mod 256), sample←wave(mode,phase+1), strb←1.
  5. Otherwise: cnt←cnt+1, strb←0.
- Rule 4 uses ≥, so lowering divisor below cnt mid-count steps on the next cycle. It never runs past the new divisor.
- Phase wraps 0xFF→0x00 silently, with no extra strobe or stall.
- Off mode with en=1 still advances phase and strobes; sample stays 0x00.
- mode_q tracks mode even while en=0. Raising en therefore starts from phase 0 without a spurious mode-change strobe.

## Timing
- Reset values: sample=0x00, sample_strb=0, phase=0, cnt=0, mode_q=0.
- Reset is asynchronous; asserting it mid-note clears all state immediately. The first step after release occurs divisor cycles after the first cycle with en=1.
- Step latency: with en=1 and divisor=D≥1, strobes occur every D cycles. sample and sample_strb change on the same edge.
- Mode-change response: sample and strb update on the first edge after the mode change is seen. The next step follows D cycles later.
- divisor=1: strobe every cycle, sample advances every cycle.
- Simultaneous en fall and mode change: en wins; mode_q still updates.

## Structure
- Shared package synth_pkg:
  - mode_t enum (MODE_OFF=0, MODE_SQUARE=1, MODE_TRIANGLE=2, MODE_SAW=3), shared with the mode FSM
  - SAMPLE_W constant
  - sample value constants 0x00 and 0xFF
- Sub-module wave_shaper: purely combinational wave(m,p) mapping. It is reused by the sequential top for both the mode-change and step paths.

## Test plan
- Sawtooth, divisor=2, en=1: sample 0x01, 0x02, … with strb every 2 cycles. After 512 cycles sample wraps 0xFF→0x00 with a strobe.
- Triangle, divisor=1: phase 64→0x80, 127→0xFE, 128→0xFF, 192→0x7F, 255→0x01.
- Square, divisor=3: sample 0x00 through phase 127, then 0xFF from phase 128 (strobe at cycle 384). Back to 0x00 at phase 0.
- Mode change saw→square at phase 0x90: the next edge gives sample=0x00 and strb=1, phase restarts at 0. divisor=0 then holds sample with no strobes.
- en drop mid-note: the next edge gives sample=0x00 with no strobe. Re-raising en with divisor=4 gives the first strobe 4 cycles later with sample=wave(mode,1).
- Async reset mid-count: outputs clear without a clock edge. Lowering divisor from 100 to 5 while cnt=50 steps on the next cycle.
